// File: rtl/boot_rom_req_adapter.sv
// Adapts a req/gnt master port onto a synchronous boot ROM. Reads inside the ROM
// window go to the ROM; writes and out-of-range reads return an error response.
module boot_rom_req_adapter #(
  parameter int unsigned ROM_ADDR_WIDTH = 13,
  parameter logic [31:0] BASE_ADDR      = 32'h1A00_0000,
  parameter logic [31:0] ERR_RDATA      = 32'hBADA_CCE5
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] add_i,
  input  logic        wen_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        r_valid_o,
  output logic [31:0] r_rdata_o,
  output logic        r_opc_o,
  input  logic        r_ready_i,
  output logic        rom_csn_o,
  output logic [31:0] rom_add_o,
  input  logic [31:0] rom_rdata_i
);

  logic        inflight_q, inflight_d;
  logic        err_q, err_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [32:0] fifo_q [2];

  logic        good;
  logic [1:0]  credits_used;
  logic        fifo_empty;
  logic [31:0] resp_data;
  logic        push, pop;
  logic        unused_inputs;

  assign unused_inputs = ^{be_i, wdata_i, add_i[1:0]};

  assign good = wen_i && (add_i[31:ROM_ADDR_WIDTH] == BASE_ADDR[31:ROM_ADDR_WIDTH]);

  // At most two responses may be owed: one in the ROM pipeline plus buffered ones.
  assign credits_used = {1'b0, inflight_q} + cnt_q;
  assign gnt_o        = rst_ni && req_i && (credits_used < 2'd2);

  assign rom_csn_o = ~(req_i && gnt_o && good);
  assign rom_add_o = {{(32-ROM_ADDR_WIDTH){1'b0}}, add_i[ROM_ADDR_WIDTH-1:2], 2'b00};

  assign fifo_empty = (cnt_q == 2'd0);
  assign resp_data  = err_q ? ERR_RDATA : rom_rdata_i;

  assign r_valid_o = inflight_q || !fifo_empty;

  always_comb begin
    r_rdata_o = 32'd0;
    r_opc_o   = 1'b0;
    if (!fifo_empty) begin
      {r_opc_o, r_rdata_o} = fifo_q[rd_ptr_q];
    end else if (inflight_q) begin
      r_opc_o   = err_q;
      r_rdata_o = resp_data;
    end
  end

  // The inflight response is buffered whenever it cannot go straight out.
  assign push = inflight_q && (!fifo_empty || !r_ready_i);
  assign pop  = !fifo_empty && r_ready_i;

  always_comb begin
    inflight_d = gnt_o;
    err_d      = gnt_o ? !good : err_q;
    wr_ptr_d   = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d   = pop  ? ~rd_ptr_q : rd_ptr_q;
    cnt_d      = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 2'd1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= {err_q, resp_data};
    end
  end

endmodule

// File: tb/tb_boot_rom_req_adapter.sv
// Directed bench for boot_rom_req_adapter: vector table plus throughput and reset sequences.
module tb_boot_rom_req_adapter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, gnt, wen, r_valid, r_opc, r_ready, rom_csn;
  logic [31:0] add, r_rdata, rom_add, rom_rdata;
  logic [3:0]  be;
  logic [31:0] wdata;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  boot_rom_req_adapter dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_i      (req),
    .gnt_o      (gnt),
    .add_i      (add),
    .wen_i      (wen),
    .be_i       (be),
    .wdata_i    (wdata),
    .r_valid_o  (r_valid),
    .r_rdata_o  (r_rdata),
    .r_opc_o    (r_opc),
    .r_ready_i  (r_ready),
    .rom_csn_o  (rom_csn),
    .rom_add_o  (rom_add),
    .rom_rdata_i(rom_rdata)
  );

  function automatic logic [31:0] rom_word(input int idx);
    return {16'hC0DE, 16'(idx)};
  endfunction

  // Synchronous ROM model: data appears the cycle after chip select.
  always @(posedge clk) begin
    if (!rom_csn) rom_rdata <= rom_word(int'(rom_add[12:2]));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic        req;
    logic [31:0] add;
    logic        wen;
    logic        rdy;
    logic        gnt;
    logic        csn;
    logic        valid;
    logic [31:0] rdata;
    logic        opc;
    logic [31:0] radd;
  } vec_t;

  vec_t vecs [13];

  task automatic drive(input logic r, input logic [31:0] a, input logic w, input logic rd);
    @(posedge clk);
    #1;
    req = r; add = a; wen = w; r_ready = rd;
    @(negedge clk);
  endtask

  initial begin
    // read hit, write, out-of-range read, then the no-ready backpressure sequence
    vecs[0]  = '{1, 32'h1A00_0010, 1, 1, 1, 0, 0, 32'h0,          0, 32'h10};
    vecs[1]  = '{1, 32'h1A00_0000, 0, 1, 1, 1, 1, 32'hC0DE_0004,  0, 32'h0};
    vecs[2]  = '{1, 32'h1B00_0000, 1, 1, 1, 1, 1, 32'hBADA_CCE5,  1, 32'h0};
    vecs[3]  = '{0, 32'h1A00_0000, 1, 1, 0, 1, 1, 32'hBADA_CCE5,  1, 32'h0};
    vecs[4]  = '{0, 32'h1A00_0000, 1, 1, 0, 1, 0, 32'h0,          0, 32'h0};
    vecs[5]  = '{1, 32'h1A00_0000, 1, 0, 1, 0, 0, 32'h0,          0, 32'h0};
    vecs[6]  = '{1, 32'h1A00_0004, 1, 0, 1, 0, 1, 32'hC0DE_0000,  0, 32'h4};
    vecs[7]  = '{1, 32'h1A00_0008, 1, 0, 0, 1, 1, 32'hC0DE_0000,  0, 32'h8};
    vecs[8]  = '{1, 32'h1A00_0008, 1, 0, 0, 1, 1, 32'hC0DE_0000,  0, 32'h8};
    vecs[9]  = '{1, 32'h1A00_0008, 1, 1, 0, 1, 1, 32'hC0DE_0000,  0, 32'h8};
    vecs[10] = '{1, 32'h1A00_0008, 1, 1, 1, 0, 1, 32'hC0DE_0001,  0, 32'h8};
    vecs[11] = '{0, 32'h1A00_0000, 1, 1, 0, 1, 1, 32'hC0DE_0002,  0, 32'h0};
    vecs[12] = '{0, 32'h1A00_0000, 1, 1, 0, 1, 0, 32'h0,          0, 32'h0};

    rst_n = 1'b0; req = 1'b1; add = 32'h1A00_0000; wen = 1'b1; r_ready = 1'b1;
    be = 4'hF; wdata = 32'h1234_5678; rom_rdata = 32'h0;
    #3;
    check("rst_gnt",   32'(gnt),     32'd0);
    check("rst_csn",   32'(rom_csn), 32'd1);
    check("rst_valid", 32'(r_valid), 32'd0);
    check("rst_rdata", r_rdata,      32'd0);
    check("rst_opc",   32'(r_opc),   32'd0);
    req = 1'b0;
    #10 rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].req, vecs[i].add, vecs[i].wen, vecs[i].rdy);
      check($sformatf("v%0d_gnt", i),   32'(gnt),     32'(vecs[i].gnt));
      check($sformatf("v%0d_csn", i),   32'(rom_csn), 32'(vecs[i].csn));
      check($sformatf("v%0d_valid", i), 32'(r_valid), 32'(vecs[i].valid));
      if (vecs[i].valid) begin
        check($sformatf("v%0d_rdata", i), r_rdata,    vecs[i].rdata);
        check($sformatf("v%0d_opc", i),   32'(r_opc), 32'(vecs[i].opc));
      end
      check($sformatf("v%0d_radd", i),  rom_add,      vecs[i].radd);
    end

    // back-to-back reads at full throughput
    begin
      int grants = 0;
      for (int k = 0; k <= 8; k++) begin
        drive(k < 8, 32'h1A00_0000 + 32'(k * 4), 1'b1, 1'b1);
        if (gnt) grants++;
        if (k >= 1) begin
          check($sformatf("b2b%0d_valid", k), 32'(r_valid), 32'd1);
          check($sformatf("b2b%0d_rdata", k), r_rdata,      rom_word(k - 1));
        end
      end
      check("b2b_grants", 32'(grants), 32'd8);
    end

    // reset with two responses buffered
    drive(1'b1, 32'h1A00_0000, 1'b1, 1'b0);
    drive(1'b1, 32'h1A00_0004, 1'b1, 1'b0);
    drive(1'b1, 32'h1A00_0008, 1'b1, 1'b0);
    check("pre_rst_valid", 32'(r_valid), 32'd1);
    check("pre_rst_gnt",   32'(gnt),     32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(r_valid), 32'd0);
    check("mid_rst_gnt",   32'(gnt),     32'd0);
    check("mid_rst_csn",   32'(rom_csn), 32'd1);
    check("mid_rst_rdata", r_rdata,      32'd0);
    req = 1'b0; r_ready = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 32'h1A00_0000, 1'b1, 1'b1);
      check($sformatf("post_rst%0d_valid", k), 32'(r_valid), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
